// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: immediate-format codes and instruction width shared by the pipeline
package imm_pkg;
  localparam int INSTR_W = 32;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake, payload and statistics bundle of the immediate pipeline
//   master: producer/consumer side (drives in_*, instr, ImmSrc, out_ready, clr_stats)
//   slave : pipeline side (drives in_ready, out_*, ImmOp, imm_count, illegal_seen)
interface imm_gen_pipe_if import imm_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_W-1:0]    instr;
  logic [2:0]            ImmSrc;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ImmOp;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_illegal;
  logic [CNT_WIDTH-1:0]  imm_count;
  logic                  illegal_seen;
  logic                  clr_stats;
  modport master (
    output in_valid, instr, ImmSrc, in_tag, out_ready, clr_stats,
    input  in_ready, out_valid, ImmOp, out_tag, out_illegal, imm_count, illegal_seen
  );
  modport slave (
    input  in_valid, instr, ImmSrc, in_tag, out_ready, clr_stats,
    output in_ready, out_valid, ImmOp, out_tag, out_illegal, imm_count, illegal_seen
  );
endinterface

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational I/S/B/U/J immediate assembly with sign extension to DATA_WIDTH
//   instr   in  raw instruction word
//   imm_src in  format select, codes above IMM_J are illegal
//   imm     out sign-extended immediate, 0 for illegal codes
//   illegal out imm_src was not a defined format
module imm_extract import imm_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [INSTR_W-1:0]    instr,
  input  logic [2:0]            imm_src,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  illegal
);
  logic [31:0] imm32;
  logic        unused_opcode;
  assign unused_opcode = ^instr[6:0];
  // every format is built as a 32-bit signed value first, so widening to RV64 is one sign extension
  always_comb begin
    imm32 = imm_src == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
            imm_src == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            imm_src == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            imm_src == IMM_U ? {instr[31:12], 12'b0} :
            imm_src == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'b0;
    illegal = imm_src > 3'(IMM_J);
    imm     = DATA_WIDTH'($signed(imm32));
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage valid/ready immediate generator with tag passthrough and saturating stats
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset, clears all stages and statistics
//   bus   slave modport of imm_gen_pipe_if (input beat, result beat, statistics, clr_stats)
module imm_gen_pipe import imm_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_pipe_if.slave bus
);
  logic                  s1_valid, s2_valid, s1_ready, s2_ready, out_fire;
  logic [INSTR_W-1:0]    s1_instr;
  logic [2:0]            s1_src;
  logic [TAG_WIDTH-1:0]  s1_tag, s2_tag;
  logic [DATA_WIDTH-1:0] s2_imm, ext_imm;
  logic                  s2_illegal, ext_illegal;
  logic [CNT_WIDTH-1:0]  count;
  logic                  seen;
  imm_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
    .instr   (s1_instr),
    .imm_src (s1_src),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );
  assign s2_ready = !s2_valid || bus.out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign out_fire = s2_valid && bus.out_ready;
  assign bus.in_ready     = s1_ready;
  assign bus.out_valid    = s2_valid;
  assign bus.ImmOp        = s2_imm;
  assign bus.out_tag      = s2_tag;
  assign bus.out_illegal  = s2_illegal;
  assign bus.imm_count    = count;
  assign bus.illegal_seen = seen;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_instr   <= '0;
      s1_src     <= '0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_imm     <= '0;
      s2_tag     <= '0;
      s2_illegal <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= bus.in_valid;
      if (s1_ready && bus.in_valid) begin
        s1_instr <= bus.instr;
        s1_src   <= bus.ImmSrc;
        s1_tag   <= bus.in_tag;
      end
      if (s2_ready) s2_valid <= s1_valid;
      if (s2_ready && s1_valid) begin
        s2_imm     <= ext_imm;
        s2_tag     <= s1_tag;
        s2_illegal <= ext_illegal;
      end
    end
  end
  // clr_stats takes priority over a same-cycle handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      seen  <= 1'b0;
    end else if (bus.clr_stats) begin
      count <= '0;
      seen  <= 1'b0;
    end else if (out_fire) begin
      count <= &count ? count : count + 1'b1;
      seen  <= seen | s2_illegal;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vector table plus handshake corner sequences for imm_gen_pipe
module tb_imm_gen_pipe;
  import imm_pkg::*;
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [31:0] imm;
    logic        ill;
  } vec_t;
  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        ill;
    int          acc;
    bit          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit chk_lat = 1'b0;
  exp_t q[$];
  vec_t vecs[12];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  imm_gen_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(16)) b();
  imm_gen_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(5), .CNT_WIDTH(2))  w();
  imm_gen_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  imm_gen_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5), .CNT_WIDTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(w)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag,
                      input logic [31:0] imm, input logic ill);
    int n = 0;
    b.in_valid = 1'b1;
    b.instr    = instr;
    b.ImmSrc   = src;
    b.in_tag   = tag;
    @(negedge clk);
    while (!b.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!b.in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout tag %0d: in_ready stayed 0, expected 1", tag);
    end else q.push_back('{imm, tag, ill, cyc + 1, chk_lat});
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    #1;
    check("drain_left", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  // scoreboard: every consumed result must match the oldest accepted beat
  always @(negedge clk) begin
    if (rst_n && b.out_valid && b.out_ready) begin
      exp_t e;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: tag %0d emitted, expected none", b.out_tag);
      end else begin
        e = q.pop_front();
        check("imm", 64'(b.ImmOp), 64'(e.imm));
        check("tag", 64'(b.out_tag), 64'(e.tag));
        check("illegal", 64'(b.out_illegal), 64'(e.ill));
        if (e.lat) check("latency", 64'(cyc + 1 - e.acc), 64'd2);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs = '{
      '{32'hFFF00093, 3'd0, 5'd1,  32'hFFFFFFFF, 1'b0},
      '{32'hFE512E23, 3'd1, 5'd2,  32'hFFFFFFFC, 1'b0},
      '{32'h00000463, 3'd2, 5'd3,  32'h00000008, 1'b0},
      '{32'hFFDFF06F, 3'd4, 5'd4,  32'hFFFFFFFC, 1'b0},
      '{32'h123450B7, 3'd3, 5'd5,  32'h12345000, 1'b0},
      '{32'h00500093, 3'd0, 5'd6,  32'h00000005, 1'b0},
      '{32'h00112623, 3'd1, 5'd7,  32'h0000000C, 1'b0},
      '{32'hFE000EE3, 3'd2, 5'd8,  32'hFFFFFFFC, 1'b0},
      '{32'h0080006F, 3'd4, 5'd9,  32'h00000008, 1'b0},
      '{32'h800000B7, 3'd3, 5'd10, 32'h80000000, 1'b0},
      '{32'hFFFFFFFF, 3'd7, 5'd11, 32'h00000000, 1'b1},
      '{32'hABCDEF37, 3'd5, 5'd12, 32'h00000000, 1'b1}
    };
    b.in_valid = 0; b.instr = 0; b.ImmSrc = 0; b.in_tag = 0; b.out_ready = 1; b.clr_stats = 0;
    w.in_valid = 0; w.instr = 0; w.ImmSrc = 0; w.in_tag = 0; w.out_ready = 1; w.clr_stats = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(b.out_valid), 64'd0);
    check("rst_in_ready", 64'(b.in_ready), 64'd1);
    check("rst_imm", 64'(b.ImmOp), 64'd0);
    check("rst_tag", 64'(b.out_tag), 64'd0);
    check("rst_illegal", 64'(b.out_illegal), 64'd0);
    check("rst_count", 64'(b.imm_count), 64'd0);
    check("rst_seen", 64'(b.illegal_seen), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // RV64 sign extension and 2-bit saturating counter on the wide instance
    w.in_valid = 1'b1;
    w.instr    = 32'h800000B7;
    w.ImmSrc   = 3'd3;
    repeat (4) @(posedge clk);
    #1;
    check("w_count_2", 64'(w.imm_count), 64'd2);
    w.instr  = 32'hFFF00093;
    w.ImmSrc = 3'd0;
    @(posedge clk);
    #1;
    w.in_valid = 1'b0;
    check("w_valid", 64'(w.out_valid), 64'd1);
    check("w_imm_u64", w.ImmOp, 64'hFFFFFFFF80000000);
    @(posedge clk);
    #1;
    check("w_imm_i64", w.ImmOp, 64'hFFFFFFFFFFFFFFFF);
    repeat (2) @(posedge clk);
    #1;
    check("w_count_sat", 64'(w.imm_count), 64'd3);
    check("w_idle", 64'(w.out_valid), 64'd0);
    // back-to-back table with no backpressure
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++)
      push(vecs[i].instr, vecs[i].src, vecs[i].tag, vecs[i].imm, vecs[i].ill);
    drain();
    check("table_count", 64'(b.imm_count), 64'd12);
    check("table_seen", 64'(b.illegal_seen), 64'd1);
    b.clr_stats = 1'b1;
    @(posedge clk);
    #1;
    b.clr_stats = 1'b0;
    check("clr_count", 64'(b.imm_count), 64'd0);
    check("clr_seen", 64'(b.illegal_seen), 64'd0);
    push(32'h12345678, 3'd7, 5'd20, 32'h0, 1'b1);
    drain();
    check("ill_seen_set", 64'(b.illegal_seen), 64'd1);
    check("ill_count", 64'(b.imm_count), 64'd1);
    // clear coinciding with an illegal handshake
    chk_lat = 1'b0;
    b.out_ready = 1'b0;
    push(32'hFFFFFFFF, 3'd6, 5'd21, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("clr_hs_valid", 64'(b.out_valid), 64'd1);
    b.out_ready = 1'b1;
    b.clr_stats = 1'b1;
    @(posedge clk);
    #1;
    b.clr_stats = 1'b0;
    check("clr_hs_count", 64'(b.imm_count), 64'd0);
    check("clr_hs_seen", 64'(b.illegal_seen), 64'd0);
    check("clr_hs_empty", 64'(q.size()), 64'd0);
    // backpressure: two beats held, then a 3-cycle stall
    b.out_ready = 1'b0;
    push(32'h00100093, 3'd0, 5'd1, 32'h1, 1'b0);
    push(32'h00200093, 3'd0, 5'd2, 32'h2, 1'b0);
    fork
      begin
        push(32'h00300093, 3'd0, 5'd3, 32'h3, 1'b0);
        push(32'h00400093, 3'd0, 5'd4, 32'h4, 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", 64'(b.in_ready), 64'd0);
          check("bp_valid", 64'(b.out_valid), 64'd1);
          check("bp_imm_hold", 64'(b.ImmOp), 64'd1);
          check("bp_tag_hold", 64'(b.out_tag), 64'd1);
        end
        @(posedge clk);
        #1;
        b.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(b.imm_count), 64'd4);
    // asynchronous reset with two beats in flight
    chk_lat = 1'b1;
    push(32'h00A00093, 3'd0, 5'd10, 32'hA, 1'b0);
    push(32'h00B00093, 3'd0, 5'd11, 32'hB, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(b.out_valid), 64'd0);
    check("mid_rst_count", 64'(b.imm_count), 64'd0);
    check("mid_rst_in_ready", 64'(b.in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'hFFD00093, 3'd0, 5'd12, 32'hFFFFFFFD, 1'b0);
    drain();
    check("post_rst_count", 64'(b.imm_count), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
